// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types, widths and latency helper for the modexp engine
package rsa_pkg;

  localparam int RSA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REDUCE,
    ST_SQUARE,
    ST_MULT,
    ST_NEXT,
    ST_FINISH
  } rsa_state_e;

  typedef enum logic [1:0] {
    MM_IDLE,
    MM_RUN,
    MM_OUT
  } mm_state_e;

  // cycles from start-accept edge to done for a legal modulus
  function automatic int rsa_latency(input int width, input int exp_width,
                                     input logic [63:0] exponent);
    int ones;
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < exp_width && exponent[i]) ones = ones + 1;
    end
    return 2 + (width + 1) * (1 + exp_width + ones);
  endfunction

endpackage

// File: rtl/rsa_modmul.sv
// rtl/rsa_modmul.sv - interleaved shift-add modular multiplier, fixed WIDTH+1 latency
module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mm_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             mm_done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mm_state_e        state_q;
  logic [WIDTH-1:0] a_q, b_q, n_q;
  logic [WIDTH+1:0] p_q, p_d;
  logic [WIDTH+1:0] sum, red1, n_ext, b_ext;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  assign n_ext = {2'b00, n_q};
  assign b_ext = {2'b00, b_q};

  // one MSB-first step: P = 2P + (a_i ? b : 0), then at most two subtractions of n
  always_comb begin
    sum  = (p_q << 1) + (a_q[WIDTH-1] ? b_ext : '0);
    red1 = (sum >= n_ext) ? (sum - n_ext) : sum;
    p_d  = (red1 >= n_ext) ? (red1 - n_ext) : red1;
  end

  // counter-driven IDLE/RUN/OUT sequencing; OUT also accepts a back-to-back start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MM_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MM_IDLE, MM_OUT: begin
          if (mm_start) begin
            a_q     <= a;
            b_q     <= b;
            n_q     <= n;
            p_q     <= '0;
            cnt_q   <= '0;
            state_q <= MM_RUN;
          end else begin
            state_q <= MM_IDLE;
          end
        end
        MM_RUN: begin
          p_q   <= p_d;
          a_q   <= a_q << 1;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= MM_OUT;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= MM_IDLE;
      endcase
    end
  end

  assign mm_done = done_q;
  assign product = p_q[WIDTH-1:0];

endmodule

// File: rtl/rsa_modexp_engine.sv
// rtl/rsa_modexp_engine.sv - left-to-right square-and-multiply modular exponentiation
module rsa_modexp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH     = RSA_WIDTH,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [WIDTH-1:0]     result
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  rsa_state_e           state_q;
  logic [WIDTH-1:0]     base_q, mod_q, acc_q, b_q, result_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 busy_q, done_q, error_q;

  logic                 mm_start, mm_done;
  logic [WIDTH-1:0]     mm_a, mm_b, mm_product;
  logic                 last_bit;

  assign last_bit = (idx_q == '0);

  // multiplier launch: the next operation issues in the same cycle the previous one completes
  always_comb begin
    mm_start = 1'b0;
    mm_a     = acc_q;
    mm_b     = acc_q;
    case (state_q)
      ST_CHECK: begin
        if (mod_q >= TWO) begin
          mm_start = 1'b1;
          mm_a     = base_q;
          mm_b     = ONE;
        end
      end
      ST_REDUCE: begin
        mm_start = mm_done;
      end
      ST_SQUARE: begin
        if (mm_done) begin
          if (exp_q[idx_q]) begin
            mm_start = 1'b1;
            mm_a     = mm_product;
            mm_b     = b_q;
          end else if (!last_bit) begin
            mm_start = 1'b1;
            mm_a     = mm_product;
            mm_b     = mm_product;
          end
        end
      end
      ST_MULT: begin
        if (mm_done && !last_bit) begin
          mm_start = 1'b1;
          mm_a     = mm_product;
          mm_b     = mm_product;
        end
      end
      default: ;
    endcase
  end

  rsa_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk     (clk),
    .reset   (reset),
    .mm_start(mm_start),
    .a       (mm_a),
    .b       (mm_b),
    .n       (mod_q),
    .mm_done (mm_done),
    .product (mm_product)
  );

  // engine sequencing: operand capture, exponent scan, registered result and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      mod_q    <= '0;
      exp_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q  <= base;
            exp_q   <= exponent;
            mod_q   <= modulus;
            idx_q   <= IDX_TOP;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (mod_q < TWO) begin
            error_q  <= 1'b1;
            result_q <= '0;
            state_q  <= ST_FINISH;
          end else begin
            acc_q   <= ONE;
            state_q <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          if (mm_done) begin
            b_q     <= mm_product;
            state_q <= ST_SQUARE;
          end
        end
        ST_SQUARE: begin
          if (mm_done) begin
            acc_q <= mm_product;
            if (exp_q[idx_q]) begin
              state_q <= ST_MULT;
            end else if (last_bit) begin
              result_q <= mm_product;
              state_q  <= ST_FINISH;
            end else begin
              idx_q <= idx_q - 1'b1;
            end
          end
        end
        ST_MULT: begin
          if (mm_done) begin
            acc_q <= mm_product;
            if (last_bit) begin
              result_q <= mm_product;
              state_q  <= ST_FINISH;
            end else begin
              idx_q   <= idx_q - 1'b1;
              state_q <= ST_SQUARE;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;
  assign result = result_q;

endmodule

// File: tb/tb_rsa_modexp_engine.sv
// tb/tb_rsa_modexp_engine.sv - self-checking bench for rsa_modexp_engine
module tb_rsa_modexp_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [31:0] base, exponent, modulus;
  logic        busy, done, error;
  logic [31:0] result;

  logic        s_start;
  logic [15:0] s_base, s_exp, s_mod;
  logic        s_busy, s_done, s_error;
  logic [15:0] s_result;

  rsa_modexp_engine #(.WIDTH(32), .EXP_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
    .modulus(modulus), .busy(busy), .done(done), .error(error), .result(result)
  );

  rsa_modexp_engine #(.WIDTH(16), .EXP_WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(s_start), .base(s_base), .exponent(s_exp),
    .modulus(s_mod), .busy(s_busy), .done(s_done), .error(s_error), .result(s_result)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
    logic [31:0] m;
    logic [31:0] r;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // right-to-left binary exponentiation on plain 64-bit integers
  function automatic logic [63:0] model_modexp(input logic [63:0] b, input logic [63:0] e,
                                               input logic [63:0] n, input int ew);
    logic [63:0] r, bb;
    if (n < 2) return 64'd0;
    r  = 64'd1;
    bb = b % n;
    for (int i = 0; i < ew; i++) begin
      if (e[i]) r = (r * bb) % n;
      bb = (bb * bb) % n;
    end
    return r;
  endfunction

  function automatic int model_latency(input int w, input int ew, input logic [63:0] e,
                                       input logic [63:0] n);
    if (n < 2) return 2;
    return 2 + (w + 1) * (1 + ew + $countones(e));
  endfunction

  task automatic run32(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m,
                       input int poke_at, output logic [31:0] r, output logic er,
                       output int lat);
    @(negedge clk);
    base = b; exponent = e; modulus = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 5000) begin
      @(posedge clk);
      lat++;
      #1;
      base = $urandom; exponent = $urandom; modulus = $urandom;
      start = (lat == poke_at);
    end
    start = 1'b0;
    r  = result;
    er = error;
    @(posedge clk);
    #1;
    check("done_pulse", {63'd0, done}, 64'd0);
    check("busy_after_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic do32(input string name, input logic [31:0] b, input logic [31:0] e,
                      input logic [31:0] m, input logic [31:0] r_exp, input logic er_exp,
                      input int poke_at, output logic [31:0] r);
    logic er;
    int   lat;
    run32(b, e, m, poke_at, r, er, lat);
    check({name, "_result"}, {32'd0, r}, {32'd0, r_exp});
    check({name, "_error"}, {63'd0, er}, {63'd0, er_exp});
    check({name, "_latency"}, 64'(lat), 64'(model_latency(32, 32, {32'd0, e}, {32'd0, m})));
  endtask

  task automatic run16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                       input string name);
    int lat;
    @(negedge clk);
    s_base = b; s_exp = e; s_mod = m; s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    lat = 0;
    while (s_done !== 1'b1 && lat < 5000) begin
      @(posedge clk);
      lat++;
      #1;
    end
    check({name, "_result"}, {48'd0, s_result},
          model_modexp({48'd0, b}, {48'd0, e}, {48'd0, m}, 16));
    check({name, "_error"}, {63'd0, s_error}, {63'd0, (m < 16'd2)});
    check({name, "_latency"}, 64'(lat), 64'(model_latency(16, 16, {48'd0, e}, {48'd0, m})));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r, dec, rb, re, rm;
    int          e_pub;
    int          lat;
    logic        er;

    reset = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
    s_start = 1'b0; s_base = '0; s_exp = '0; s_mod = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_error", {63'd0, error}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    check("reset16_result", {48'd0, s_result}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    vecs[0] = '{32'd4, 32'd13, 32'd497, 32'd445, 1'b0};
    vecs[1] = '{32'd12524, 32'd6851, 32'd23213,
                32'(model_modexp(64'd12524, 64'd6851, 64'd23213, 32)), 1'b0};
    vecs[2] = '{32'd77, 32'd5, 32'd1, 32'd0, 1'b1};
    vecs[3] = '{32'd99999, 32'd0, 32'd23213, 32'd1, 1'b0};
    vecs[4] = '{32'd0, 32'd5, 32'd23213, 32'd0, 1'b0};
    vecs[5] = '{32'd23220, 32'd1, 32'd23213, 32'd7, 1'b0};
    vecs[6] = '{32'd5, 32'd7, 32'd0, 32'd0, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB,
                32'(model_modexp(64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFB, 32)), 1'b0};

    for (int i = 0; i < 8; i++) begin
      do32($sformatf("vec%0d", i), vecs[i].b, vecs[i].e, vecs[i].m, vecs[i].r, vecs[i].err,
           -1, r);
      if (i == 1) dec = r;
    end

    e_pub = 0;
    for (int k = 1; k < 22908; k++) begin
      if ((6851 * k) % 22908 == 1) e_pub = k;
    end
    do32("encrypt", dec, 32'(e_pub), 32'd23213, 32'd12524, 1'b0, -1, r);

    for (int i = 0; i < 6; i++) begin
      rb = $urandom;
      re = $urandom;
      rm = (i == 2) ? 32'd2 : $urandom;
      do32($sformatf("rand%0d", i), rb, re, rm,
           32'(model_modexp({32'd0, rb}, {32'd0, re}, {32'd0, rm}, 32)), (rm < 32'd2), -1, r);
    end

    do32("start_ignored", 32'd4, 32'd13, 32'd497, 32'd445, 1'b0, 300, r);

    @(negedge clk);
    base = 32'd12524; exponent = 32'd6851; modulus = 32'd23213; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (200) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", {63'd0, done}, 64'd0);
    run32(32'd12524, 32'd6851, 32'd23213, -1, r, er, lat);
    check("after_abort_result", {32'd0, r}, model_modexp(64'd12524, 64'd6851, 64'd23213, 32));
    check("after_abort_latency", 64'(lat), 64'(model_latency(32, 32, 64'd6851, 64'd23213)));

    run16(16'hFFFF, 16'hFFFF, 16'd65521, "w16_max");
    for (int i = 0; i < 3; i++) begin
      run16(16'($urandom), 16'($urandom), 16'($urandom), $sformatf("w16_rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
